// File: rtl/cla_adder_iterative_if.sv
// rtl/cla_adder_iterative_if.sv - start/busy/done operand and result bundle for the iterative CLA adder
interface cla_adder_iterative_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             zero;

  // Requester side: issues operations, observes handshake and results
  modport master (
    output start, sub, a, b, c_in,
    input  busy, done, sum, c_out, overflow, zero
  );

  // Adder side
  modport slave (
    input  start, sub, a, b, c_in,
    output busy, done, sum, c_out, overflow, zero
  );
endinterface

// File: rtl/cla_adder_iterative.sv
// rtl/cla_adder_iterative.sv - multi-cycle chunked carry-lookahead add/sub; optional CLA_SATURATE_EN clamps on overflow
module cla_adder_iterative #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cla_adder_iterative_if.slave bus
);

  // WIDTH must be a multiple of CHUNK; N chunks are processed LSB first.
  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              c_out_q, c_out_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic              accept;
  logic              last;
  int                base;
  logic [CHUNK-1:0]  chunk_a, chunk_b, gen, prop, chunk_s;
  logic [CHUNK:0]    carry_v;
  logic              term, prod;
  logic [WIDTH-1:0]  sum_next, sum_final;
  logic              ovf_v;

  // A start is only honoured when no operation is in flight.
  assign accept = bus.start && (state_q != ST_BUSY);
  assign last   = (idx_q == IDXW'(N - 1));

  // State and datapath registers; async reset aborts any operation and clears results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state: IDLE/DONE accept a start, BUSY runs until the last chunk
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (last)   state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state
  always_comb begin
    bus.busy = (state_q == ST_BUSY);
    bus.done = (state_q == ST_DONE);
  end

  // Current chunk: generate/propagate and flattened lookahead carries from the registered carry-in
  always_comb begin
    base    = int'(idx_q) * CHUNK;
    chunk_a = a_q[base +: CHUNK];
    chunk_b = b_q[base +: CHUNK];
    gen     = chunk_a & chunk_b;
    prop    = chunk_a ^ chunk_b;
    carry_v = '0;
    carry_v[0] = carry_q;
    term    = 1'b0;
    prod    = 1'b0;
    for (int k = 0; k < CHUNK; k++) begin
      // c[k+1] = g[k] | p[k]g[k-1] | ... | p[k..0]c[0]
      term = carry_q;
      for (int j = 0; j <= k; j++) begin
        term = term & prop[j];
      end
      for (int j = 0; j <= k; j++) begin
        prod = gen[j];
        for (int m = j + 1; m <= k; m++) begin
          prod = prod & prop[m];
        end
        term = term | prod;
      end
      carry_v[k+1] = term;
    end
    chunk_s = prop ^ carry_v[CHUNK-1:0];
  end

  // Datapath next values: operand capture on start, chunk write-back while busy, flags at the last chunk
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    sum_next = sum_q;
    sum_next[base +: CHUNK] = chunk_s;
    // On the last chunk carry_v[CHUNK-1] is the carry into the MSB.
    ovf_v     = carry_v[CHUNK] ^ carry_v[CHUNK-1];
    sum_final = sum_next;
`ifdef CLA_SATURATE_EN
    if (ovf_v) begin
      sum_final = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif

    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b ^ {WIDTH{bus.sub}};
      carry_d = bus.sub | bus.c_in;
      idx_d   = '0;
    end else if (state_q == ST_BUSY) begin
      carry_d = carry_v[CHUNK];
      idx_d   = idx_q + 1'b1;
      sum_d   = sum_next;
      if (last) begin
        idx_d   = '0;
        sum_d   = sum_final;
        c_out_d = carry_v[CHUNK];
        ovf_d   = ovf_v;
        zero_d  = (sum_final == '0);
      end
    end
  end

  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;

endmodule
